// File: rtl/csa_pkg.sv
// csa_pkg: shared types and sizing helpers for the carry-save resolver.
// Holds the FSM state encoding, the default vector/chunk widths and the
// constant functions that derive the chunk count and counter width.
package csa_pkg;

  localparam int DATA_SIZE_DEF = 256;
  localparam int CHUNK_DEF     = 64;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Number of CHUNK-wide slices in a DATA_SIZE-wide vector.
  function automatic int num_chunks(input int data_size, input int chunk);
    return data_size / chunk;
  endfunction

  // Chunk counter width; at least one bit so a single-chunk build still has a counter.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/csa_resolve_if.sv
// csa_resolve_if: operand/result handshake bundle for csa_resolve.
// The master side produces operands and consumes the result; the slave side
// is the resolver. With CSA_RESOLVE_CIN_EN defined, a carry-in bit travels
// alongside the operands.
interface csa_resolve_if
  import csa_pkg::*;
#(
  parameter int DATA_SIZE = DATA_SIZE_DEF
);
  logic                 in_valid;
  logic                 in_ready;
  logic [DATA_SIZE-1:0] s_in;
  logic [DATA_SIZE-1:0] c_in;
`ifdef CSA_RESOLVE_CIN_EN
  logic                 cin;
`endif
  logic                 out_valid;
  logic                 out_ready;
  logic [DATA_SIZE+1:0] out_sum;

  modport master (
`ifdef CSA_RESOLVE_CIN_EN
    output cin,
`endif
    output in_valid, s_in, c_in, out_ready,
    input  in_ready, out_valid, out_sum
  );

  modport slave (
`ifdef CSA_RESOLVE_CIN_EN
    input  cin,
`endif
    input  in_valid, s_in, c_in, out_ready,
    output in_ready, out_valid, out_sum
  );

endinterface

// File: rtl/cpa_chunk.sv
// cpa_chunk: CHUNK-bit unsigned adder with carry-in and carry-out.
// One instance is time-shared across all slices of the operand.
module cpa_chunk
  import csa_pkg::*;
#(
  parameter int CHUNK = CHUNK_DEF
) (
  input  logic [CHUNK-1:0] a,
  input  logic [CHUNK-1:0] b,
  input  logic             cin,
  output logic [CHUNK-1:0] sum,
  output logic             cout
);

  assign {cout, sum} = {1'b0, a} + {1'b0, b} + {{CHUNK{1'b0}}, cin};

endmodule

// File: rtl/csa_resolve.sv
// csa_resolve: resolves a carry-save (sum, carry) pair into a binary sum,
// CHUNK bits per cycle through a single shared adder, with valid/ready on
// both sides. Optional macro CSA_RESOLVE_CIN_EN adds a carry-in that is
// injected into chunk 0 (result = s_in + (c_in << 1) + cin).
module csa_resolve
  import csa_pkg::*;
#(
  parameter int DATA_SIZE = DATA_SIZE_DEF,
  parameter int CHUNK     = CHUNK_DEF
) (
  input logic          clk,
  input logic          reset,
  csa_resolve_if.slave bus
);

  localparam int            N      = num_chunks(DATA_SIZE, CHUNK);
  localparam int            KW     = cnt_width(N);
  localparam logic [KW-1:0] K_LAST = KW'(N - 1);

  generate
    if ((DATA_SIZE % CHUNK) != 0) begin : g_size_check
      $error("csa_resolve: DATA_SIZE must be a multiple of CHUNK");
    end
  endgenerate

  state_t               state_q;
  state_t               state_d;
  logic [KW-1:0]        k_q;
  logic                 carry_q;
  logic [DATA_SIZE-1:0] s_p0;
  logic [DATA_SIZE-1:0] cs_p0;
  logic                 ctop_p0;
  logic [DATA_SIZE+1:0] sum_p1;
  logic                 vld_p1;
  logic                 accept;
  logic                 last;
  logic                 carry_init;
  logic [CHUNK-1:0]     chunk_s;
  logic [CHUNK-1:0]     chunk_cs;
  logic [CHUNK-1:0]     chunk_sum;
  logic                 chunk_cout;

  assign accept   = (state_q == IDLE) && bus.in_valid;
  assign last     = (k_q == K_LAST);
  assign chunk_s  = s_p0[k_q*CHUNK +: CHUNK];
  assign chunk_cs = cs_p0[k_q*CHUNK +: CHUNK];

`ifdef CSA_RESOLVE_CIN_EN
  assign carry_init = bus.cin;
`else
  assign carry_init = 1'b0;
`endif

  cpa_chunk #(
    .CHUNK (CHUNK)
  ) u_chunk (
    .a    (chunk_s),
    .b    (chunk_cs),
    .cin  (carry_q),
    .sum  (chunk_sum),
    .cout (chunk_cout)
  );

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next-state decode: accept in IDLE, walk the chunks in RUN, hold in DONE until taken.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus.in_valid)  state_d = RUN;
      RUN:     if (last)          state_d = DONE;
      DONE:    if (bus.out_ready) state_d = IDLE;
      default:                    state_d = IDLE;
    endcase
  end

  // Stage p0 -> p1: chunk counter, inter-chunk carry and the result/valid registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      k_q     <= '0;
      carry_q <= 1'b0;
      sum_p1  <= '0;
      vld_p1  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept) begin
            k_q     <= '0;
            carry_q <= carry_init;
          end
        end
        RUN: begin
          sum_p1[k_q*CHUNK +: CHUNK] <= chunk_sum;
          carry_q                    <= chunk_cout;
          if (last) begin
            // The carry vector's MSB sits at weight 2^DATA_SIZE after the shift,
            // so it joins the final carry-out in the two extra result bits.
            sum_p1[DATA_SIZE+1:DATA_SIZE] <= {1'b0, ctop_p0} + {1'b0, chunk_cout};
            k_q                           <= '0;
            vld_p1                        <= 1'b1;
          end else begin
            k_q <= k_q + KW'(1);
          end
        end
        DONE: begin
          if (bus.out_ready) vld_p1 <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  // Stage p0: operand capture on accept; carry vector is pre-shifted into sum alignment.
  always_ff @(posedge clk) begin
    if (accept) begin
      s_p0    <= bus.s_in;
      cs_p0   <= {bus.c_in[DATA_SIZE-2:0], 1'b0};
      ctop_p0 <= bus.c_in[DATA_SIZE-1];
    end
  end

  assign bus.in_ready  = (state_q == IDLE);
  assign bus.out_valid = vld_p1;
  assign bus.out_sum   = sum_p1;

endmodule

// File: tb/tb_csa_resolve.sv
// tb_csa_resolve: self-checking bench for csa_resolve (DATA_SIZE=256, CHUNK=64).
// Honours CSA_RESOLVE_CIN_EN when the design is built with it.
module tb_csa_resolve;

  localparam int DW    = 256;
  localparam int LIMIT = 20;

  typedef struct {
    string          name;
    logic [DW-1:0]  s;
    logic [DW-1:0]  c;
    logic           ci;
    logic [DW+1:0]  exp;
  } vec_t;

  logic clk;
  logic reset;
  int   errors;
  int   checks;

  csa_resolve_if #(.DATA_SIZE(DW)) bus ();

  csa_resolve #(
    .DATA_SIZE (DW),
    .CHUNK     (64)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: the plain integer value of the carry-save pair.
  function automatic logic [DW+1:0] ref_sum(input logic [DW-1:0] s, input logic [DW-1:0] c,
                                            input logic ci);
    logic [DW+1:0] r;
    r = {2'b00, s} + {1'b0, c, 1'b0} + {{(DW+1){1'b0}}, ci};
    return r;
  endfunction

  task automatic chk_vec(input string n, input logic [DW+1:0] got, input logic [DW+1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", n, got, exp);
    end
  endtask

  task automatic chk_int(input string n, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", n, got, exp);
    end
  endtask

  // Waits for in_ready, presents one operand pair for one cycle; returns #1 after the accept edge.
  task automatic start_op(input logic [DW-1:0] s, input logic [DW-1:0] c, input logic ci,
                          output bit ok);
    ok = 1'b0;
    for (int i = 0; i < LIMIT; i++) begin
      @(negedge clk);
      if (bus.in_ready === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      chk_int("in_ready_timeout", 0, 1);
      return;
    end
    bus.s_in     = s;
    bus.c_in     = c;
`ifdef CSA_RESOLVE_CIN_EN
    bus.cin      = ci;
`else
    if (ci) $display("note: cin ignored in this build");
`endif
    bus.in_valid = 1'b1;
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
  endtask

  // Counts rising edges after the accept edge until out_valid is seen at a falling edge.
  task automatic wait_valid(output int lat, output bit ok);
    ok  = 1'b0;
    lat = -1;
    for (int i = 0; i < LIMIT; i++) begin
      @(negedge clk);
      if (bus.out_valid === 1'b1) begin
        lat = i;
        ok  = 1'b1;
        break;
      end
    end
    if (!ok) chk_int("out_valid_timeout", 0, 1);
  endtask

  task automatic run_op(input string n, input logic [DW-1:0] s, input logic [DW-1:0] c,
                        input logic ci, input logic [DW+1:0] exp);
    bit ok;
    int lat;
    start_op(s, c, ci, ok);
    if (!ok) return;
    wait_valid(lat, ok);
    if (!ok) return;
    chk_int({n, "_latency"}, lat, 4);
    chk_vec({n, "_sum"}, bus.out_sum, exp);
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1 bus.out_ready = 1'b0;
  endtask

  function automatic logic [DW-1:0] rand_vec();
    logic [DW-1:0] v;
    int mode;
    mode = $urandom_range(0, 3);
    for (int j = 0; j < DW / 32; j++) v[j*32 +: 32] = $urandom;
    if (mode == 1) v = ~'0;
    if (mode == 2) v[DW-1:DW/2] = '0;
    return v;
  endfunction

  vec_t          vecs[$];
  logic [DW-1:0] ones;
  logic [DW+1:0] exp_v;
  logic [DW-1:0] rs;
  logic [DW-1:0] rc;
  logic          rci;
  bit            ok;
  int            lat;

  initial begin
    errors        = 0;
    checks        = 0;
    ones          = '1;
    reset         = 1'b1;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    bus.s_in      = '0;
    bus.c_in      = '0;
`ifdef CSA_RESOLVE_CIN_EN
    bus.cin       = 1'b0;
`endif

    vecs.push_back('{"all_ones_s",  ones, '0, 1'b0, {2'b00, ones}});
    vecs.push_back('{"all_ones_sc", ones, ones, 1'b0, {2'b10, {(DW-2){1'b1}}, 2'b01}});
    vecs.push_back('{"chunk0_cross", DW'({64{1'b1}}), DW'(1), 1'b0, (DW+2)'(1) << 64 | (DW+2)'(1)});
    vecs.push_back('{"zero",        '0, '0, 1'b0, '0});
    vecs.push_back('{"c_msb_only",  '0, {1'b1, {(DW-1){1'b0}}}, 1'b0, {2'b01, {DW{1'b0}}}});
    vecs.push_back('{"s_one",       DW'(1), '0, 1'b0, (DW+2)'(1)});
`ifdef CSA_RESOLVE_CIN_EN
    vecs.push_back('{"cin_wrap",    ones, '0, 1'b1, {2'b01, {DW{1'b0}}}});
`endif

    // Reset state.
    repeat (2) @(posedge clk);
    #1;
    chk_int("rst_in_ready", int'(bus.in_ready), 1);
    chk_int("rst_out_valid", int'(bus.out_valid), 0);
    chk_vec("rst_out_sum", bus.out_sum, '0);
    @(negedge clk);
    reset = 1'b0;

    // Directed table.
    foreach (vecs[i]) run_op(vecs[i].name, vecs[i].s, vecs[i].c, vecs[i].ci, vecs[i].exp);

    // Randomised operands against the reference.
    for (int it = 0; it < 30; it++) begin
      rs  = rand_vec();
      rc  = rand_vec();
`ifdef CSA_RESOLVE_CIN_EN
      rci = 1'($urandom_range(0, 1));
`else
      rci = 1'b0;
`endif
      run_op("rand", rs, rc, rci, ref_sum(rs, rc, rci));
    end

    // Consumer stall with an ignored in_valid pulse.
    rs    = rand_vec();
    rc    = rand_vec();
    exp_v = ref_sum(rs, rc, 1'b0);
    start_op(rs, rc, 1'b0, ok);
    if (ok) wait_valid(lat, ok);
    if (ok) begin
      chk_vec("stall_first", bus.out_sum, exp_v);
      for (int i = 0; i < 6; i++) begin
        if (i == 2) begin
          bus.s_in     = ~rs;
          bus.c_in     = ~rc;
          bus.in_valid = 1'b1;
        end
        if (i == 4) bus.in_valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk_int("stall_out_valid", int'(bus.out_valid), 1);
        chk_vec("stall_out_sum", bus.out_sum, exp_v);
        chk_int("stall_in_ready", int'(bus.in_ready), 0);
      end
      bus.out_ready = 1'b1;
      @(posedge clk);
      #1 bus.out_ready = 1'b0;
      @(negedge clk);
      chk_int("stall_release_in_ready", int'(bus.in_ready), 1);
      chk_int("stall_release_out_valid", int'(bus.out_valid), 0);
      @(posedge clk);
      @(negedge clk);
      chk_int("stall_no_second_accept", int'(bus.in_ready), 1);
      chk_vec("stall_result_kept", bus.out_sum, exp_v);
    end

    // Reset in the middle of RUN (k=2), then a clean operation.
    start_op(ones, '0, 1'b0, ok);
    if (ok) begin
      @(posedge clk);
      @(posedge clk);
      #1 reset = 1'b1;
      #1;
      chk_int("midrun_rst_out_valid", int'(bus.out_valid), 0);
      chk_vec("midrun_rst_out_sum", bus.out_sum, '0);
      chk_int("midrun_rst_in_ready", int'(bus.in_ready), 1);
      @(negedge clk);
      reset = 1'b0;
      rs = rand_vec();
      rc = rand_vec();
      run_op("after_rst", rs, rc, 1'b0, ref_sum(rs, rc, 1'b0));
    end

    repeat (2) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
